// File: rtl/multi_dataflow_streamer_tcdm_arbiter_pkg.sv
// Shared types and helpers for the streamer TCDM port-sharing stage.
//
// Contents:
//   NB_CH_DEF            : default channel count, sizes ch_id_t.
//   ch_id_t              : channel identifier for the default configuration.
//   flags_tcdm_arbiter_t : status flags {busy, err} exported by the arbiter.
//   ch2port()            : static channel -> TCDM port mapping (c % nb_ports).
package multi_dataflow_streamer_package;

  localparam int NB_CH_DEF = 4;

  typedef logic [$clog2(NB_CH_DEF)-1:0] ch_id_t;

  typedef struct packed {
    logic busy;
    logic err;
  } flags_tcdm_arbiter_t;

  function automatic int ch2port(input int c, input int nb_ports);
    return c % nb_ports;
  endfunction

endpackage

// File: rtl/multi_dataflow_streamer_tcdm_arbiter_id_fifo.sv
// In-order FIFO of channel IDs, one per TCDM port, used to route read
// responses back to the channel that issued the read.
//
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset.
//   clear_i        : synchronous soft clear (empties the FIFO).
//   push_i, data_i : enqueue an ID (ignored when full).
//   pop_i          : dequeue the head ID (ignored when empty).
//   data_o         : head ID, valid while empty_o=0.
//   full_o, empty_o: occupancy flags.
module multi_dataflow_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/multi_dataflow_streamer_tcdm_arbiter.sv
// TCDM port-sharing stage between NB_CH streamer channels and NB_PORTS TCDM
// master ports. Channel c is statically mapped to port c % NB_PORTS; channels
// sharing a port are arbitrated round-robin. Read responses are steered back
// through a per-port in-order ID FIFO that also bounds outstanding reads.
//
// Handshake: a port request is accepted on a cycle where tcdm_req_o and
// tcdm_gnt_i are both high; once raised without grant the request (and its
// address/wen/be/data source) is held on the same channel until granted.
// Read responses carry no ready: tcdm_r_valid_i is consumed the cycle it is seen.
//
// Ports:
//   clk_i, rst_i, clear_i : clock, sync active-high reset, sync soft clear.
//   enable_i              : 0 blocks new (unlocked) requests.
//   ch_*                  : streamer-side channel request/grant/response buses.
//   tcdm_*                : TCDM master port request/grant/response buses.
//   busy_o                : outstanding reads or a locked request on any port.
//   err_o                 : sticky, response seen with an empty ID FIFO.
module multi_dataflow_streamer_tcdm_arbiter
  import multi_dataflow_streamer_package::*;
#(
  parameter int NB_CH     = 4,
  parameter int NB_PORTS  = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     enable_i,
  input  logic [NB_CH-1:0]         ch_req_i,
  output logic [NB_CH-1:0]         ch_gnt_o,
  input  logic [NB_CH*AW-1:0]      ch_add_i,
  input  logic [NB_CH-1:0]         ch_wen_i,
  input  logic [NB_CH*DW/8-1:0]    ch_be_i,
  input  logic [NB_CH*DW-1:0]      ch_data_i,
  output logic [NB_CH*DW-1:0]      ch_r_data_o,
  output logic [NB_CH-1:0]         ch_r_valid_o,
  output logic [NB_PORTS-1:0]      tcdm_req_o,
  input  logic [NB_PORTS-1:0]      tcdm_gnt_i,
  output logic [NB_PORTS*AW-1:0]   tcdm_add_o,
  output logic [NB_PORTS-1:0]      tcdm_wen_o,
  output logic [NB_PORTS*DW/8-1:0] tcdm_be_o,
  output logic [NB_PORTS*DW-1:0]   tcdm_data_o,
  input  logic [NB_PORTS*DW-1:0]   tcdm_r_data_i,
  input  logic [NB_PORTS-1:0]      tcdm_r_valid_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int BW   = DW / 8;
  localparam int ID_W = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam int SW   = ID_W + 1;

  logic                w_clr;
  logic [ID_W-1:0]     w_sel  [NB_PORTS];
  logic [ID_W-1:0]     w_head [NB_PORTS];
  logic [NB_PORTS-1:0] w_req;
  logic [NB_PORTS-1:0] w_full;
  logic [NB_PORTS-1:0] w_empty;
  logic [NB_PORTS-1:0] w_locked;

  logic [AW-1:0] w_ch_add  [NB_CH];
  logic [BW-1:0] w_ch_be   [NB_CH];
  logic [DW-1:0] w_ch_data [NB_CH];

  logic                r_err;
  flags_tcdm_arbiter_t w_flags;

  assign w_clr = rst_i | clear_i;

  for (genvar c = 0; c < NB_CH; c++) begin : g_ch_unpack
    assign w_ch_add[c]  = ch_add_i[c*AW +: AW];
    assign w_ch_be[c]   = ch_be_i[c*BW +: BW];
    assign w_ch_data[c] = ch_data_i[c*DW +: DW];
  end

  // ---------------------------------------------------------------------------
  // Per-port arbitration, lock and read tracking
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
    logic [NB_CH-1:0] w_elig;
    logic [ID_W-1:0]  r_rr;
    logic [ID_W-1:0]  r_lock_ch;
    logic             r_lock;
    logic [ID_W-1:0]  w_win;
    logic             w_any;
    logic             w_grant;
    logic             w_push;
    logic [SW-1:0]    w_nxt_sum;
    logic [ID_W-1:0]  w_rr_nxt;

    // Unmapped channels are never eligible, so the search below can walk
    // every channel index and still only ever land on this port's set.
    for (genvar c = 0; c < NB_CH; c++) begin : g_elig
      if (ch2port(c, NB_PORTS) == p) begin : g_mapped
        assign w_elig[c] = ch_req_i[c] & (~ch_wen_i[c] | ~w_full[p]);
      end else begin : g_unmapped
        assign w_elig[c] = 1'b0;
      end
    end

    // First eligible channel at or after the RR pointer, wrapping at NB_CH.
    always_comb begin
      logic [SW-1:0] v_idx;
      w_win = r_rr;
      w_any = 1'b0;
      v_idx = '0;
      for (int o = 0; o < NB_CH; o++) begin
        v_idx = {1'b0, r_rr} + SW'(o);
        if (v_idx >= SW'(NB_CH)) v_idx = v_idx - SW'(NB_CH);
        if (!w_any && w_elig[v_idx[ID_W-1:0]]) begin
          w_any = 1'b1;
          w_win = v_idx[ID_W-1:0];
        end
      end
    end

    assign w_sel[p]    = r_lock ? r_lock_ch : w_win;
    assign w_req[p]    = r_lock | (enable_i & w_any);
    assign w_grant     = w_req[p] & tcdm_gnt_i[p];
    assign w_push      = w_grant & ch_wen_i[w_sel[p]];
    assign w_locked[p] = r_lock;

    // Next mapped channel after the winner; past the top it wraps to p,
    // the lowest channel mapped to this port.
    assign w_nxt_sum = {1'b0, w_sel[p]} + SW'(NB_PORTS);
    assign w_rr_nxt  = (w_nxt_sum >= SW'(NB_CH)) ? ID_W'(p) : w_nxt_sum[ID_W-1:0];

    always_ff @(posedge clk_i) begin
      if (w_clr) begin
        r_rr      <= ID_W'(p);
        r_lock    <= 1'b0;
        r_lock_ch <= ID_W'(p);
      end else if (w_grant) begin
        r_rr   <= w_rr_nxt;
        r_lock <= 1'b0;
      end else if (w_req[p]) begin
        r_lock    <= 1'b1;
        r_lock_ch <= w_sel[p];
      end
    end

    multi_dataflow_id_fifo #(
      .W     (ID_W),
      .DEPTH (MAX_OUTST)
    ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .push_i  (w_push),
      .data_i  (w_sel[p]),
      .pop_i   (tcdm_r_valid_i[p]),
      .data_o  (w_head[p]),
      .full_o  (w_full[p]),
      .empty_o (w_empty[p])
    );

    assign tcdm_req_o[p]            = w_req[p];
    assign tcdm_add_o[p*AW +: AW]   = w_ch_add[w_sel[p]];
    assign tcdm_wen_o[p]            = ch_wen_i[w_sel[p]];
    assign tcdm_be_o[p*BW +: BW]    = w_ch_be[w_sel[p]];
    assign tcdm_data_o[p*DW +: DW]  = w_ch_data[w_sel[p]];
  end

  // ---------------------------------------------------------------------------
  // Channel-side grant and response demux (each channel listens to one port)
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NB_CH; c++) begin : g_ch_out
    localparam int PC = ch2port(c, NB_PORTS);
    assign ch_gnt_o[c]     = tcdm_gnt_i[PC] & w_req[PC] & (w_sel[PC] == ID_W'(c));
    assign ch_r_valid_o[c] = tcdm_r_valid_i[PC] & ~w_empty[PC] & (w_head[PC] == ID_W'(c));
    assign ch_r_data_o[c*DW +: DW] = tcdm_r_data_i[PC*DW +: DW];
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_err <= 1'b0;
    end else if (|(tcdm_r_valid_i & w_empty)) begin
      r_err <= 1'b1;
    end
  end

  assign w_flags.busy = |(w_locked | ~w_empty);
  assign w_flags.err  = r_err;
  assign busy_o       = w_flags.busy;
  assign err_o        = w_flags.err;

endmodule

// File: tb/tb_multi_dataflow_streamer_tcdm_arbiter.sv
module tb_multi_dataflow_streamer_tcdm_arbiter;

  localparam int NB_CH     = 4;
  localparam int NB_PORTS  = 2;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int BW        = DW / 8;
  localparam int MAX_OUTST = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                     rst_i;
  logic                     clear_i;
  logic                     enable_i;
  logic [NB_CH-1:0]         ch_req_i;
  logic [NB_CH-1:0]         ch_gnt_o;
  logic [NB_CH*AW-1:0]      ch_add_i;
  logic [NB_CH-1:0]         ch_wen_i;
  logic [NB_CH*BW-1:0]      ch_be_i;
  logic [NB_CH*DW-1:0]      ch_data_i;
  logic [NB_CH*DW-1:0]      ch_r_data_o;
  logic [NB_CH-1:0]         ch_r_valid_o;
  logic [NB_PORTS-1:0]      tcdm_req_o;
  logic [NB_PORTS-1:0]      tcdm_gnt_i;
  logic [NB_PORTS*AW-1:0]   tcdm_add_o;
  logic [NB_PORTS-1:0]      tcdm_wen_o;
  logic [NB_PORTS*BW-1:0]   tcdm_be_o;
  logic [NB_PORTS*DW-1:0]   tcdm_data_o;
  logic [NB_PORTS*DW-1:0]   tcdm_r_data_i;
  logic [NB_PORTS-1:0]      tcdm_r_valid_i;
  logic                     busy_o;
  logic                     err_o;

  multi_dataflow_streamer_tcdm_arbiter #(
    .NB_CH(NB_CH), .NB_PORTS(NB_PORTS), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .enable_i       (enable_i),
    .ch_req_i       (ch_req_i),
    .ch_gnt_o       (ch_gnt_o),
    .ch_add_i       (ch_add_i),
    .ch_wen_i       (ch_wen_i),
    .ch_be_i        (ch_be_i),
    .ch_data_i      (ch_data_i),
    .ch_r_data_o    (ch_r_data_o),
    .ch_r_valid_o   (ch_r_valid_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  // ---------------- stimulus model ----------------
  int errors = 0;
  int checks = 0;
  int tag    = 0;
  logic [NB_CH-1:0] cur_wen;

  function automatic logic [AW-1:0] addr_of(input int c, input int t);
    return {16'hA0A0, 8'(c), 8'(t)};
  endfunction
  function automatic logic [DW-1:0] wdata_of(input int c, input int t);
    return {16'hD0D0, 8'(c), 8'(t)};
  endfunction
  function automatic logic [BW-1:0] be_of(input int c);
    logic [BW-1:0] v;
    v = 4'b0001;
    return v << c;
  endfunction
  function automatic logic [DW-1:0] rdata_of(input int p, input int t);
    return {16'hBEEF, 8'(p), 8'(t)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic clr, input logic en,
                       input logic [3:0] req, input logic [3:0] wen,
                       input logic [1:0] gnt, input logic [1:0] rv);
    rst_i          = rst;
    clear_i        = clr;
    enable_i       = en;
    ch_req_i       = req;
    ch_wen_i       = wen;
    cur_wen        = wen;
    tcdm_gnt_i     = gnt;
    tcdm_r_valid_i = rv;
    for (int c = 0; c < NB_CH; c++) begin
      ch_add_i[c*AW +: AW]  = addr_of(c, tag);
      ch_data_i[c*DW +: DW] = wdata_of(c, tag);
      ch_be_i[c*BW +: BW]   = be_of(c);
    end
    for (int p = 0; p < NB_PORTS; p++) tcdm_r_data_i[p*DW +: DW] = rdata_of(p, tag);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_cycle(input string nm, input logic [1:0] e_req,
                             input logic [3:0] e_gnt, input logic [3:0] e_rv,
                             input logic e_busy, input logic e_err,
                             input int sel0, input int sel1);
    int s;
    chk({nm, ".tcdm_req"}, 64'(tcdm_req_o), 64'(e_req));
    chk({nm, ".ch_gnt"}, 64'(ch_gnt_o), 64'(e_gnt));
    chk({nm, ".ch_r_valid"}, 64'(ch_r_valid_o), 64'(e_rv));
    chk({nm, ".busy"}, 64'(busy_o), 64'(e_busy));
    chk({nm, ".err"}, 64'(err_o), 64'(e_err));
    for (int p = 0; p < NB_PORTS; p++) begin
      if (e_req[p]) begin
        s = (p == 0) ? sel0 : sel1;
        chk($sformatf("%s.add%0d", nm, p), 64'(tcdm_add_o[p*AW +: AW]), 64'(addr_of(s, tag)));
        chk($sformatf("%s.wen%0d", nm, p), 64'(tcdm_wen_o[p]), 64'(cur_wen[s]));
        chk($sformatf("%s.be%0d", nm, p), 64'(tcdm_be_o[p*BW +: BW]), 64'(be_of(s)));
        chk($sformatf("%s.data%0d", nm, p), 64'(tcdm_data_o[p*DW +: DW]), 64'(wdata_of(s, tag)));
      end
    end
    for (int c = 0; c < NB_CH; c++) begin
      if (e_rv[c]) begin
        chk($sformatf("%s.r_data%0d", nm, c), 64'(ch_r_data_o[c*DW +: DW]),
            64'(rdata_of(c % NB_PORTS, tag)));
      end
    end
  endtask

  task automatic step(input string nm, input logic clr, input logic en,
                      input logic [3:0] req, input logic [3:0] wen,
                      input logic [1:0] gnt, input logic [1:0] rv,
                      input logic [1:0] e_req, input logic [3:0] e_gnt,
                      input logic [3:0] e_rv, input logic e_busy, input logic e_err,
                      input int sel0, input int sel1);
    drive(1'b0, clr, en, req, wen, gnt, rv);
    @(negedge clk_i);
    check_cycle(nm, e_req, e_gnt, e_rv, e_busy, e_err, sel0, sel1);
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       clr, en;
    logic [3:0] req, wen;
    logic [1:0] gnt, rv;
    logic [1:0] e_req;
    logic [3:0] e_gnt, e_rv;
    logic       e_busy, e_err;
    int         sel0, sel1;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic clr, input logic en, input logic [3:0] req,
                              input logic [3:0] wen, input logic [1:0] gnt,
                              input logic [1:0] rv, input logic [1:0] e_req,
                              input logic [3:0] e_gnt, input logic [3:0] e_rv,
                              input logic e_busy, input logic e_err,
                              input int sel0, input int sel1);
    vec_t v;
    v.clr = clr; v.en = en; v.req = req; v.wen = wen; v.gnt = gnt; v.rv = rv;
    v.e_req = e_req; v.e_gnt = e_gnt; v.e_rv = e_rv;
    v.e_busy = e_busy; v.e_err = e_err; v.sel0 = sel0; v.sel1 = sel1;
    return v;
  endfunction

  initial begin
    //               clr en  req     wen     gnt    rv     e_req  e_gnt   e_rv    bsy err s0 s1
    // reset state
    vecs[0]  = mk(0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 1);
    // ch0/ch2 continuous reads on port0, responses routed back in order
    vecs[1]  = mk(0, 1, 4'b0101, 4'b0101, 2'b01, 2'b00, 2'b01, 4'b0001, 4'b0000, 0, 0, 0, 1);
    vecs[2]  = mk(0, 1, 4'b0101, 4'b0101, 2'b01, 2'b01, 2'b01, 4'b0100, 4'b0001, 1, 0, 2, 1);
    vecs[3]  = mk(0, 1, 4'b0101, 4'b0101, 2'b01, 2'b01, 2'b01, 4'b0001, 4'b0100, 1, 0, 0, 1);
    vecs[4]  = mk(0, 1, 4'b0101, 4'b0101, 2'b01, 2'b01, 2'b01, 4'b0100, 4'b0001, 1, 0, 2, 1);
    vecs[5]  = mk(0, 1, 4'b0000, 4'b0000, 2'b01, 2'b01, 2'b00, 4'b0000, 4'b0100, 1, 0, 0, 1);
    vecs[6]  = mk(0, 1, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 1);
    // spurious response on port1, sticky err, clear
    vecs[7]  = mk(0, 1, 4'b0000, 4'b0000, 2'b00, 2'b10, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 1);
    vecs[8]  = mk(0, 1, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 1, 0, 1);
    vecs[9]  = mk(1, 1, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 1, 0, 1);
    vecs[10] = mk(0, 1, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 1);
    // lock on port0 survives enable_i=0, then no new request until enable_i=1
    vecs[11] = mk(0, 1, 4'b0001, 4'b0000, 2'b00, 2'b00, 2'b01, 4'b0000, 4'b0000, 0, 0, 0, 1);
    vecs[12] = mk(0, 0, 4'b0001, 4'b0000, 2'b00, 2'b00, 2'b01, 4'b0000, 4'b0000, 1, 0, 0, 1);
    vecs[13] = mk(0, 0, 4'b0001, 4'b0000, 2'b01, 2'b00, 2'b01, 4'b0001, 4'b0000, 1, 0, 0, 1);
    vecs[14] = mk(0, 0, 4'b0001, 4'b0000, 2'b01, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 1);
    vecs[15] = mk(0, 1, 4'b0001, 4'b0000, 2'b01, 2'b00, 2'b01, 4'b0001, 4'b0000, 0, 0, 0, 1);
    // both ports in parallel, RR within each mapped set
    vecs[16] = mk(0, 1, 4'b1111, 4'b0000, 2'b11, 2'b00, 2'b11, 4'b0110, 4'b0000, 0, 0, 2, 1);
    vecs[17] = mk(0, 1, 4'b1111, 4'b0000, 2'b11, 2'b00, 2'b11, 4'b1001, 4'b0000, 0, 0, 0, 3);
    vecs[18] = mk(0, 1, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 1);

    tag = 0;
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, 2'b00);
    repeat (3) @(posedge clk_i);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      tag = i + 1;
      step($sformatf("vec%0d", i), vecs[i].clr, vecs[i].en, vecs[i].req, vecs[i].wen,
           vecs[i].gnt, vecs[i].rv, vecs[i].e_req, vecs[i].e_gnt, vecs[i].e_rv,
           vecs[i].e_busy, vecs[i].e_err, vecs[i].sel0, vecs[i].sel1);
    end

    // ch1 write held 3 cycles without grant while ch3 also requests (rr1=ch1)
    tag = 100;
    step("lock_a", 0, 1, 4'b1010, 4'b0000, 2'b00, 2'b00, 2'b10, 4'b0000, 4'b0000, 0, 0, 0, 1);
    step("lock_b", 0, 1, 4'b1010, 4'b0000, 2'b00, 2'b00, 2'b10, 4'b0000, 4'b0000, 1, 0, 0, 1);
    step("lock_c", 0, 1, 4'b1010, 4'b0000, 2'b00, 2'b00, 2'b10, 4'b0000, 4'b0000, 1, 0, 0, 1);
    step("lock_d", 0, 1, 4'b1010, 4'b0000, 2'b10, 2'b00, 2'b10, 4'b0010, 4'b0000, 1, 0, 0, 1);
    step("lock_e", 0, 1, 4'b1000, 4'b0000, 2'b10, 2'b00, 2'b10, 4'b1000, 4'b0000, 0, 0, 0, 3);

    // fill port0 ID FIFO with four ch0 reads, then check the hold-off
    tag = 110;
    for (int k = 0; k < MAX_OUTST; k++) begin
      step($sformatf("fill%0d", k), 0, 1, 4'b0001, 4'b0001, 2'b01, 2'b00,
           2'b01, 4'b0001, 4'b0000, (k != 0), 0, 0, 1);
    end
    step("full_hold", 0, 1, 4'b0001, 4'b0001, 2'b01, 2'b00, 2'b00, 4'b0000, 4'b0000, 1, 0, 0, 1);
    step("full_pop", 0, 1, 4'b0001, 4'b0001, 2'b01, 2'b01, 2'b00, 4'b0000, 4'b0001, 1, 0, 0, 1);
    step("full_reiss", 0, 1, 4'b0001, 4'b0001, 2'b01, 2'b00, 2'b01, 4'b0001, 4'b0000, 1, 0, 0, 1);
    for (int k = 0; k < MAX_OUTST; k++) begin
      step($sformatf("drain%0d", k), 0, 1, 4'b0000, 4'b0000, 2'b00, 2'b01,
           2'b00, 4'b0000, 4'b0001, 1, 0, 0, 1);
    end
    step("drained", 0, 1, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 1);

    // reset with two reads outstanding; rr pointers become ch2/ch3 beforehand
    tag = 120;
    step("pre_rst", 0, 1, 4'b0011, 4'b0011, 2'b11, 2'b00, 2'b11, 4'b0011, 4'b0000, 0, 0, 0, 1);
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1111, 2'b00, 2'b00);
    @(posedge clk_i);
    #1;
    step("post_rst", 0, 1, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 1);
    step("rr_restart", 0, 1, 4'b1111, 4'b1111, 2'b11, 2'b00, 2'b11, 4'b0011, 4'b0000, 0, 0, 0, 1);
    step("rst_resp", 0, 1, 4'b0000, 4'b0000, 2'b00, 2'b11, 2'b00, 4'b0000, 4'b0011, 1, 0, 0, 1);
    step("rst_idle", 0, 1, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 1);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
